// File: rtl/sequence_key_checker_if.sv
// Keypad/key bus between the game side (master) and sequence_key_checker (slave).
interface sequence_key_checker_if #(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_STRIKES = 3
);
  localparam int IDX_W = $clog2(DIGITS) + 1;
  localparam int SC_W  = $clog2(MAX_STRIKES + 1);

  logic                        transmit;
  logic [DIGITS*DIGIT_W-1:0]   sequence_key;
  logic [DIGIT_W-1:0]          digit_in;
  logic                        digit_valid;
  logic                        clear;
  logic                        armed;
  logic [IDX_W-1:0]            digit_index;
  logic                        solved;
  logic                        strike;
  logic [SC_W-1:0]             strike_count;
  logic                        detonate;

  modport master (
    output transmit, sequence_key, digit_in, digit_valid, clear,
    input  armed, digit_index, solved, strike, strike_count, detonate
  );

  modport slave (
    input  transmit, sequence_key, digit_in, digit_valid, clear,
    output armed, digit_index, solved, strike, strike_count, detonate
  );
endinterface

// File: rtl/sequence_key_checker.sv
// Checks keypad digits in order against the latched puzzle key; reports solve/strike/detonate.
// Optional inter-digit timeout enabled by defining SEQ_CHECK_TIMEOUT_EN.
module sequence_key_checker #(
  parameter int DIGITS         = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_STRIKES    = 3,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  sequence_key_checker_if.slave bus
);
  localparam int IDX_W = $clog2(DIGITS) + 1;
  localparam int SC_W  = $clog2(MAX_STRIKES + 1);

  typedef enum logic [1:0] {IDLE, ARMED, SOLVED, DEAD} state_t;

  state_t                    r_state, w_state_next;
  logic [DIGITS*DIGIT_W-1:0] r_key, w_key_next;
  logic [IDX_W-1:0]          r_index, w_index_next;
  logic [SC_W-1:0]           r_strikes, w_strikes_next;
  logic                      r_solved, w_solved_next;
  logic                      r_strike, w_strike_next;
  logic                      r_detonate, w_detonate_next;
  logic                      r_armed;
  logic                      w_timeout;
  logic                      w_mismatch;
  logic [DIGIT_W-1:0]        w_sel;
  logic [DIGIT_W-1:0]        w_key_digit [DIGITS];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign w_key_digit[gi] = r_key[gi*DIGIT_W +: DIGIT_W];
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_index == IDX_W'(i)) w_sel = w_key_digit[i];
    end
  end

`ifdef SEQ_CHECK_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] r_timer;
  logic             w_tmr_run;

  // Runs only while a partial entry is pending and nothing else restarts it this cycle.
  assign w_tmr_run = (r_state == ARMED) && (r_index != '0) &&
                     !bus.transmit && !bus.clear && !bus.digit_valid;
  assign w_timeout = w_tmr_run && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_timer <= '0;
    else if (!w_tmr_run || w_timeout) r_timer <= '0;
    else                          r_timer <= r_timer + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_mismatch = w_timeout || (bus.digit_in != w_sel);

  always_comb begin
    w_state_next    = r_state;
    w_key_next      = r_key;
    w_index_next    = r_index;
    w_strikes_next  = r_strikes;
    w_solved_next   = 1'b0;
    w_strike_next   = 1'b0;
    w_detonate_next = r_detonate;
    case (r_state)
      IDLE, SOLVED: begin
        if (bus.transmit) begin
          w_key_next   = bus.sequence_key;
          w_index_next = '0;
          w_state_next = ARMED;
        end
      end
      ARMED: begin
        if (bus.transmit) begin
          w_key_next   = bus.sequence_key;
          w_index_next = '0;
        end else if (bus.clear) begin
          w_index_next = '0;
        end else if (bus.digit_valid || w_timeout) begin
          // A real digit wins over a timeout landing in the same cycle.
          if (bus.digit_valid ? (bus.digit_in != w_sel) : w_mismatch) begin
            w_strike_next = 1'b1;
            w_index_next  = '0;
            if (r_strikes != SC_W'(MAX_STRIKES)) w_strikes_next = r_strikes + 1'b1;
            if (r_strikes + 1'b1 >= SC_W'(MAX_STRIKES)) begin
              w_state_next    = DEAD;
              w_detonate_next = 1'b1;
            end
          end else if (r_index == IDX_W'(DIGITS - 1)) begin
            w_solved_next = 1'b1;
            w_index_next  = '0;
            w_state_next  = SOLVED;
          end else begin
            w_index_next = r_index + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_key      <= '0;
      r_index    <= '0;
      r_strikes  <= '0;
      r_solved   <= 1'b0;
      r_strike   <= 1'b0;
      r_detonate <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_key      <= w_key_next;
      r_index    <= w_index_next;
      r_strikes  <= w_strikes_next;
      r_solved   <= w_solved_next;
      r_strike   <= w_strike_next;
      r_detonate <= w_detonate_next;
      r_armed    <= (w_state_next == ARMED);
    end
  end

  assign bus.armed        = r_armed;
  assign bus.digit_index  = r_index;
  assign bus.solved       = r_solved;
  assign bus.strike       = r_strike;
  assign bus.strike_count = r_strikes;
  assign bus.detonate     = r_detonate;
endmodule

// File: tb/tb_sequence_key_checker.sv
// Directed bench for sequence_key_checker; expected outputs queued per step, checked after the edge.
module tb_sequence_key_checker;
  logic clk;
  logic rst;

  sequence_key_checker_if #(.DIGITS(4), .DIGIT_W(4), .MAX_STRIKES(3)) bus_if ();

  sequence_key_checker #(
    .DIGITS(4), .DIGIT_W(4), .MAX_STRIKES(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       armed;
    logic [2:0] idx;
    logic       solved;
    logic       strike;
    logic [1:0] sc;
    logic       det;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t mk(input logic a, input int i, input logic so,
                              input logic st, input int s, input logic d);
    exp_t e;
    e.armed = a; e.idx = 3'(i); e.solved = so; e.strike = st; e.sc = 2'(s); e.det = d;
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    n_checks++;
    assert (bus_if.armed === e.armed) n_pass++;
    else $error("FAIL %s armed got=%0b exp=%0b", tag, bus_if.armed, e.armed);
    n_checks++;
    assert (bus_if.digit_index === e.idx) n_pass++;
    else $error("FAIL %s digit_index got=%0d exp=%0d", tag, bus_if.digit_index, e.idx);
    n_checks++;
    assert (bus_if.solved === e.solved) n_pass++;
    else $error("FAIL %s solved got=%0b exp=%0b", tag, bus_if.solved, e.solved);
    n_checks++;
    assert (bus_if.strike === e.strike) n_pass++;
    else $error("FAIL %s strike got=%0b exp=%0b", tag, bus_if.strike, e.strike);
    n_checks++;
    assert (bus_if.strike_count === e.sc) n_pass++;
    else $error("FAIL %s strike_count got=%0d exp=%0d", tag, bus_if.strike_count, e.sc);
    n_checks++;
    assert (bus_if.detonate === e.det) n_pass++;
    else $error("FAIL %s detonate got=%0b exp=%0b", tag, bus_if.detonate, e.det);
  endtask

  // One clock of stimulus: drive at negedge, queue expectation, compare 1 time unit after posedge.
  task automatic step(input string tag, input logic tx, input logic [15:0] key,
                      input logic dv, input logic [3:0] d, input logic clr, input exp_t e);
    exp_t got_e;
    @(negedge clk);
    bus_if.transmit     = tx;
    bus_if.sequence_key = key;
    bus_if.digit_valid  = dv;
    bus_if.digit_in     = d;
    bus_if.clear        = clr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus_if.transmit    = 1'b0;
    bus_if.digit_valid = 1'b0;
    bus_if.clear       = 1'b0;
    got_e = sb.pop_front();
    check_outputs(tag, got_e);
    $display("step %-12s tx=%0b dv=%0b d=%0h clr=%0b -> armed=%0b idx=%0d solved=%0b strike=%0b sc=%0d det=%0b",
             tag, tx, dv, d, clr, bus_if.armed, bus_if.digit_index, bus_if.solved,
             bus_if.strike, bus_if.strike_count, bus_if.detonate);
  endtask

  task automatic dig(input string tag, input logic [3:0] d, input exp_t e);
    step(tag, 1'b0, 16'h0, 1'b1, d, 1'b0, e);
  endtask

  task automatic idle(input string tag, input exp_t e);
    step(tag, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus_if.transmit = 1'b0; bus_if.sequence_key = '0; bus_if.digit_in = '0;
    bus_if.digit_valid = 1'b0; bus_if.clear = 1'b0;
    #12;
    check_outputs("reset", mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;

    // Full solve of 0x4321
    step("tx1", 1'b1, 16'h4321, 1'b0, 4'h0, 1'b0, mk(1, 0, 0, 0, 0, 0));
    dig("d1", 4'h1, mk(1, 1, 0, 0, 0, 0));
    dig("d2", 4'h2, mk(1, 2, 0, 0, 0, 0));
    dig("d3", 4'h3, mk(1, 3, 0, 0, 0, 0));
    dig("d4", 4'h4, mk(0, 0, 1, 0, 0, 0));
    idle("post_solve", mk(0, 0, 0, 0, 0, 0));
    dig("solved_ign", 4'h1, mk(0, 0, 0, 0, 0, 0));

    // Wrong third digit, then a correct retry
    step("tx2", 1'b1, 16'h4321, 1'b0, 4'h0, 1'b0, mk(1, 0, 0, 0, 0, 0));
    dig("e1", 4'h1, mk(1, 1, 0, 0, 0, 0));
    dig("e2", 4'h2, mk(1, 2, 0, 0, 0, 0));
    dig("e9", 4'h9, mk(1, 0, 0, 1, 1, 0));
    idle("post_strike", mk(1, 0, 0, 0, 1, 0));
    dig("r1", 4'h1, mk(1, 1, 0, 0, 1, 0));
    dig("r2", 4'h2, mk(1, 2, 0, 0, 1, 0));
    dig("r3", 4'h3, mk(1, 3, 0, 0, 1, 0));
    dig("r4", 4'h4, mk(0, 0, 1, 0, 1, 0));

    // Strikes persist across levels; reach the limit
    step("tx3", 1'b1, 16'h4321, 1'b0, 4'h0, 1'b0, mk(1, 0, 0, 0, 1, 0));
    dig("w2", 4'h7, mk(1, 0, 0, 1, 2, 0));
    dig("w3", 4'h7, mk(0, 0, 0, 1, 3, 1));
    idle("dead_idle", mk(0, 0, 0, 0, 3, 1));
    step("dead_tx", 1'b1, 16'h4321, 1'b1, 4'h1, 1'b0, mk(0, 0, 0, 0, 3, 1));
    dig("dead_dig", 4'h1, mk(0, 0, 0, 0, 3, 1));

    // clear beats digit_valid; transmit beats digit_valid
    do_reset();
    step("tx4", 1'b1, 16'h4321, 1'b0, 4'h0, 1'b0, mk(1, 0, 0, 0, 0, 0));
    dig("c1", 4'h1, mk(1, 1, 0, 0, 0, 0));
    dig("c2", 4'h2, mk(1, 2, 0, 0, 0, 0));
    step("clr_dv", 1'b0, 16'h0, 1'b1, 4'h3, 1'b1, mk(1, 0, 0, 0, 0, 0));
    step("tx_dv", 1'b1, 16'h8765, 1'b1, 4'h1, 1'b0, mk(1, 0, 0, 0, 0, 0));
    dig("n5", 4'h5, mk(1, 1, 0, 0, 0, 0));
    dig("n6", 4'h6, mk(1, 2, 0, 0, 0, 0));
    dig("n7", 4'h7, mk(1, 3, 0, 0, 0, 0));
    dig("n8", 4'h8, mk(0, 0, 1, 0, 0, 0));

    // Asynchronous reset mid-entry
    step("tx5", 1'b1, 16'h4321, 1'b0, 4'h0, 1'b0, mk(1, 0, 0, 0, 0, 0));
    dig("a1", 4'h1, mk(1, 1, 0, 0, 0, 0));
    dig("a2", 4'h2, mk(1, 2, 0, 0, 0, 0));
    dig("a9", 4'h9, mk(1, 0, 0, 1, 1, 0));
    dig("a1b", 4'h1, mk(1, 1, 0, 0, 1, 0));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_outputs("async_rst", mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    dig("idle_dig", 4'h1, mk(0, 0, 0, 0, 0, 0));

`ifdef SEQ_CHECK_TIMEOUT_EN
    do_reset();
    step("tx6", 1'b1, 16'h4321, 1'b0, 4'h0, 1'b0, mk(1, 0, 0, 0, 0, 0));
    dig("t1", 4'h1, mk(1, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 15; i++) idle("t_wait", mk(1, 1, 0, 0, 0, 0));
    idle("t_expire", mk(1, 0, 0, 1, 1, 0));
    for (int i = 0; i < 100; i++) idle("t_idx0", mk(1, 0, 0, 0, 1, 0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
